multi_timer: RTL

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// multi_timer: bank of NUM_CH independent up-counting timers behind a simple
// register bus. Each channel has TH (reload), TL (count) and TCON (control).
// Optional build macro MULTI_TIMER_CASCADE_EN lets channel n>0 count channel
// n-1 overflows instead of prescaled clock ticks.
module multi_timer #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wen,
    input  logic [31:0]       address,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              IRQ
);

    localparam logic [4:0] NCH      = 5'(NUM_CH);
    localparam logic [3:0] OFF_TH   = 4'h0;
    localparam logic [3:0] OFF_TL   = 4'h4;
    localparam logic [3:0] OFF_TCON = 4'h8;

    logic [CNT_W-1:0]   th    [NUM_CH];
    logic [CNT_W-1:0]   tl    [NUM_CH];
    logic [PRESC_W-1:0] presc [NUM_CH];
    logic [PRESC_W-1:0] pcnt  [NUM_CH];
    logic [NUM_CH-1:0]  run;
    logic [NUM_CH-1:0]  ie;
    logic [NUM_CH-1:0]  pend;
    logic [NUM_CH-1:0]  oneshot;
    logic [NUM_CH-1:0]  casc;

    logic [3:0]         ch_idx;
    logic [3:0]         off;
    logic               ch_valid;
    logic [NUM_CH-1:0]  wr_ch;
    logic [NUM_CH-1:0]  psc_hit;
    logic [NUM_CH-1:0]  psc_adv;
    logic [NUM_CH-1:0]  tick;
    logic [NUM_CH-1:0]  ovf;
    logic               ovf_prev;
    logic [31:0]        tcon_rd;
    logic               unused_addr;

    assign ch_idx      = address[7:4];
    assign off         = address[3:0];
    assign ch_valid    = ({1'b0, ch_idx} < NCH);
    assign unused_addr = ^address[31:8];

`ifndef MULTI_TIMER_CASCADE_EN
    assign casc = '0;
`endif

    // Per-channel write select, prescaler match, tick and overflow; ovf_prev
    // carries the lower channel's overflow up the chain for cascade mode.
    always_comb begin
        wr_ch    = '0;
        psc_hit  = '0;
        psc_adv  = '0;
        tick     = '0;
        ovf      = '0;
        ovf_prev = 1'b0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            wr_ch[n]   = wen && ch_valid && (ch_idx == 4'(n));
            psc_hit[n] = (pcnt[n] == presc[n]);
            if (n != 0 && casc[n]) begin
                tick[n] = run[n] && !wr_ch[n] && ovf_prev;
            end else begin
                psc_adv[n] = run[n] && !wr_ch[n];
                tick[n]    = psc_adv[n] && psc_hit[n];
            end
            ovf[n]   = tick[n] && (tl[n] == '1);
            ovf_prev = ovf[n];
        end
    end

    // Counting and bus writes; a write suppresses the channel's count that
    // cycle, so write and count never compete for the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                th[n]    <= '0;
                tl[n]    <= '0;
                presc[n] <= '0;
                pcnt[n]  <= '0;
            end
            run     <= '0;
            ie      <= '0;
            pend    <= '0;
            oneshot <= '0;
`ifdef MULTI_TIMER_CASCADE_EN
            casc    <= '0;
`endif
        end else begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (psc_adv[n]) begin
                    pcnt[n] <= psc_hit[n] ? '0 : pcnt[n] + 1'b1;
                end
                if (tick[n]) begin
                    if (ovf[n]) begin
                        tl[n]   <= th[n];
                        pend[n] <= 1'b1;
                        if (oneshot[n]) begin
                            run[n] <= 1'b0;
                        end
                    end else begin
                        tl[n] <= tl[n] + 1'b1;
                    end
                end
                if (wr_ch[n]) begin
                    case (off)
                        OFF_TH: th[n] <= din[CNT_W-1:0];
                        OFF_TL: begin
                            tl[n]   <= din[CNT_W-1:0];
                            pcnt[n] <= '0;
                        end
                        OFF_TCON: begin
                            run[n]     <= din[0];
                            ie[n]      <= din[1];
                            oneshot[n] <= din[3];
`ifdef MULTI_TIMER_CASCADE_EN
                            casc[n]    <= din[4];
`endif
                            presc[n]   <= din[8 +: PRESC_W];
                            pcnt[n]    <= '0;
                            if (din[2]) begin
                                pend[n] <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Combinational read mux; unselected bus, invalid channel or reserved
    // offset all read as zero.
    always_comb begin
        dout    = '0;
        tcon_rd = '0;
        if (en && ch_valid) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (ch_idx == 4'(n)) begin
                    tcon_rd[0]              = run[n];
                    tcon_rd[1]              = ie[n];
                    tcon_rd[2]              = pend[n];
                    tcon_rd[3]              = oneshot[n];
                    tcon_rd[4]              = casc[n];
                    tcon_rd[8 +: PRESC_W]   = presc[n];
                    case (off)
                        OFF_TH:   dout = 32'(th[n]);
                        OFF_TL:   dout = 32'(tl[n]);
                        OFF_TCON: dout = tcon_rd;
                        default:  dout = '0;
                    endcase
                end
            end
        end
    end

    assign irq_vec = pend & ie;
    assign IRQ     = |irq_vec;

endmodule
